// File: rtl/system_keys_in.sv
// system_keys_in: Avalon-MM slave input PIO for push-buttons/switches.
// Two-flop synchroniser, optional per-bit debounce filter, per-bit edge capture
// (write-1-to-clear) and a maskable level interrupt.
// Optional feature: define SYSTEM_KEYS_DEBOUNCE_EN to enable the debounce filter.
// Register map: 0 = data (RO), 1 = reserved, 2 = irq_mask (RW), 3 = edge_capture (W1C).
module system_keys_in #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

`ifdef SYSTEM_KEYS_DEBOUNCE_EN
    localparam int unsigned PRIME = DEBOUNCE_CYCLES + 3;
`else
    localparam int unsigned PRIME = 3;
`endif
    localparam int unsigned PW = $clog2(PRIME + 1);
    localparam logic [PW-1:0] PrimeMax = PW'(PRIME);

    logic [WIDTH-1:0] s1_q, s2_q, prev_q;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [PW-1:0]    prime_cnt_q, prime_cnt_d;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] clr;
    logic             armed;
    logic             wr_en;

    // Two-flop synchroniser and previous-level register for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= in_port;
            s2_q   <= s1_q;
            prev_q <= filt;
        end
    end

`ifdef SYSTEM_KEYS_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] filt_q;
    logic [CW-1:0]    cnt_q [WIDTH];

    // Debounce: filt follows s2 only after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (s2_q[i] != filt_q[i]) begin
                    if (cnt_q[i] == CntMax) begin
                        filt_q[i] <= s2_q[i];
                        cnt_q[i]  <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = s2_q;
`endif

    // Priming counter: edges are ignored until the input pipeline has filled.
    always_comb begin
        armed       = (prime_cnt_q == PrimeMax);
        prime_cnt_d = armed ? prime_cnt_q : prime_cnt_q + PW'(1);
    end

    // Edge selection and register next-state (a capture beats a same-cycle clear).
    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_sel = filt & ~prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_sel = ~filt & prev_q;
        end else begin
            edge_sel = filt ^ prev_q;
        end
        wr_en          = chipselect & ~write_n;
        clr            = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        edge_capture_d = (edge_capture_q & ~clr) | (edge_sel & {WIDTH{armed}});
        irq_mask_d     = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irq_mask_q;
    end

    // Control/status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_cnt_q    <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
        end else begin
            prime_cnt_q    <= prime_cnt_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
        end
    end

    // Zero-wait-state read mux and interrupt output.
    always_comb begin
        readdata = '0;
        unique case (address)
            2'd0:    readdata[WIDTH-1:0] = filt;
            2'd2:    readdata[WIDTH-1:0] = irq_mask_q;
            2'd3:    readdata[WIDTH-1:0] = edge_capture_q;
            default: readdata = '0;
        endcase
        irq = |(edge_capture_q & irq_mask_q);
    end

endmodule

// File: tb/tb_system_keys_in.sv
// Self-checking bench for system_keys_in (default build, debounce disabled).
// Three instances cover rising, falling and any-edge capture against one
// behavioural model built from the history of sampled inputs.
module tb_system_keys_in;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd [3];
    logic        irq_w [3];

    always #5 clk = ~clk;

    system_keys_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) u_dut_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[0]), .irq(irq_w[0])
    );
    system_keys_in #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(16)) u_dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[1]), .irq(irq_w[1])
    );
    system_keys_in #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) u_dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[2]), .irq(irq_w[2])
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: every input sampled since reset, plus the register contents.
    logic [3:0] smp [$];
    logic [3:0] m_cap [3];
    logic [3:0] m_mask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Level visible at address 0 after k clock edges since reset: the input taken two edges ago.
    function automatic logic [3:0] filt_after(input int k);
        if (k < 2) return 4'h0;
        return smp[k-2];
    endfunction

    function automatic logic [3:0] sel_edge(input int et, input logic [3:0] c, input logic [3:0] p);
        if (et == 0) return c & ~p;
        if (et == 1) return ~c & p;
        return c ^ p;
    endfunction

    function automatic logic [31:0] exp_read(input int i, input logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, filt_after(smp.size())};
            2'd2:    return {28'h0, m_mask};
            2'd3:    return {28'h0, m_cap[i]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        smp.delete();
        for (int i = 0; i < 3; i++) m_cap[i] = 4'h0;
        m_mask = 4'h0;
    endtask

    // Advance the model by one clock edge with the bus/inputs presented at that edge.
    task automatic model_edge(input logic [3:0] inp, input logic wr, input logic [1:0] wa,
                              input logic [31:0] wd);
        int         n;
        logic [3:0] cur, prv, clr;
        bit         armed;
        n     = smp.size();
        cur   = filt_after(n);
        prv   = filt_after(n - 1);
        armed = (n >= 3);
        clr   = (wr && wa == 2'd3) ? wd[3:0] : 4'h0;
        for (int i = 0; i < 3; i++) begin
            m_cap[i] = (m_cap[i] & ~clr) | (armed ? sel_edge(i, cur, prv) : 4'h0);
        end
        if (wr && wa == 2'd2) m_mask = wd[3:0];
        smp.push_back(inp);
    endtask

    // One clock: drive at negedge, model at posedge, then read-back and irq checks.
    task automatic cycle(input logic [3:0] inp, input logic wr, input logic [1:0] wa,
                         input logic [31:0] wd, input logic [1:0] ra);
        @(negedge clk);
        in_port = inp;
        if (wr) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
        end else begin
            chipselect = 1'($urandom_range(0, 1));
            write_n    = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
        end
        address   = wa;
        writedata = wd;
        @(posedge clk);
        model_edge(inp, wr, wa, wd);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = ra;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rd%0d_a%0d", i, ra), rd[i], exp_read(i, ra));
            check($sformatf("irq%0d", i), {31'h0, irq_w[i]}, {31'h0, |(m_cap[i] & m_mask)});
        end
    endtask

    // Directed read of one instance/address against a constant expectation.
    task automatic read_chk(input string tag, input int i, input logic [1:0] a,
                            input logic [31:0] exp);
        address = a;
        #1;
        check(tag, rd[i], exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            for (int i = 0; i < 3; i++) check($sformatf("rst_rd%0d_a%0d", i, a), rd[i], 32'h0);
        end
        for (int i = 0; i < 3; i++) check($sformatf("rst_irq%0d", i), {31'h0, irq_w[i]}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [3:0] cur_in;
        reset      = 1'b1;
        in_port    = 4'hF;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset and priming: inputs held high from reset must not be captured.
        repeat (10) cycle(4'hF, 1'b0, 2'd0, 32'h0, 2'd3);
        for (int i = 0; i < 3; i++) begin
            read_chk("prime_cap", i, 2'd3, 32'h0);
            read_chk("prime_data", i, 2'd0, 32'hF);
            check("prime_irq", {31'h0, irq_w[i]}, 32'h0);
        end

        // Falling capture on bit 1 with irq_mask = 2.
        cycle(4'hF, 1'b1, 2'd2, 32'h2, 2'd3);
        cycle(4'hF, 1'b1, 2'd3, 32'hF, 2'd3);
        cycle(4'hD, 1'b0, 2'd0, 32'h0, 2'd3);
        read_chk("fall_e1", 1, 2'd3, 32'h0);
        cycle(4'hD, 1'b0, 2'd0, 32'h0, 2'd3);
        read_chk("fall_e2", 1, 2'd3, 32'h0);
        check("fall_irq_e2", {31'h0, irq_w[1]}, 32'h0);
        cycle(4'hD, 1'b0, 2'd0, 32'h0, 2'd3);
        read_chk("fall_e3", 1, 2'd3, 32'h2);
        check("fall_irq_e3", {31'h0, irq_w[1]}, 32'h1);
        repeat (4) cycle(4'hF, 1'b0, 2'd0, 32'h0, 2'd3);
        read_chk("fall_sticky", 1, 2'd3, 32'h2);

        // Write-1-to-clear and set-beats-clear.
        cycle(4'hF, 1'b1, 2'd3, 32'hF, 2'd3);
        repeat (3) cycle(4'hC, 1'b0, 2'd0, 32'h0, 2'd3);
        read_chk("w1c_pre", 1, 2'd3, 32'h3);
        cycle(4'hC, 1'b1, 2'd3, 32'h1, 2'd3);
        read_chk("w1c_bit0", 1, 2'd3, 32'h2);
        cycle(4'hF, 1'b1, 2'd3, 32'hF, 2'd3);
        cycle(4'hD, 1'b0, 2'd0, 32'h0, 2'd3);
        cycle(4'hD, 1'b0, 2'd0, 32'h0, 2'd3);
        read_chk("prio_pre", 1, 2'd3, 32'h0);
        cycle(4'hD, 1'b1, 2'd3, 32'h2, 2'd3);
        read_chk("prio_set_wins", 1, 2'd3, 32'h2);

        // Mask behaviour on the any-edge instance.
        cycle(4'hF, 1'b1, 2'd2, 32'h0, 2'd3);
        repeat (3) cycle(4'hF, 1'b1, 2'd3, 32'hF, 2'd3);
        repeat (3) cycle(4'hB, 1'b0, 2'd0, 32'h0, 2'd3);
        read_chk("mask_cap", 2, 2'd3, 32'h4);
        check("mask_irq_off", {31'h0, irq_w[2]}, 32'h0);
        cycle(4'hB, 1'b1, 2'd2, 32'h4, 2'd3);
        check("mask_irq_on", {31'h0, irq_w[2]}, 32'h1);
        cycle(4'hB, 1'b1, 2'd3, 32'h4, 2'd3);
        check("mask_irq_clr", {31'h0, irq_w[2]}, 32'h0);

        // Register map: data and reserved ignore writes, mask upper bits dropped.
        cycle(4'hB, 1'b1, 2'd0, 32'hFFFF_FFFF, 2'd0);
        cycle(4'hB, 1'b1, 2'd1, 32'hFFFF_FFFF, 2'd0);
        read_chk("map_data", 0, 2'd0, 32'hB);
        read_chk("map_rsvd", 0, 2'd1, 32'h0);
        cycle(4'hB, 1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2);
        read_chk("map_mask", 0, 2'd2, 32'hF);

        // Randomised traffic with a mid-run asynchronous reset.
        cur_in = 4'hB;
        for (int c = 0; c < 1500; c++) begin
            logic        wr;
            logic [1:0]  wa;
            logic [31:0] wd;
            if (c == 700) do_reset();
            if ($urandom_range(0, 3) == 0) cur_in = 4'($urandom);
            wr = ($urandom_range(0, 5) == 0);
            wa = 2'($urandom);
            wd = $urandom;
            cycle(cur_in, wr, wa, wd, 2'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
